// File: rtl/alu_md_pkg.sv
// Shared definitions for the execute-stage ALU with iterative multiply/divide:
// ealuc encodings, sequencer state encoding and opcode classification helpers.
package alu_md_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;
    localparam logic [3:0] ALU_DIV   = 4'b1001;
    localparam logic [3:0] ALU_MFHI  = 4'b1010;
    localparam logic [3:0] ALU_MFLO  = 4'b1011;
    localparam logic [3:0] ALU_MULT  = 4'b1100;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_MULTU = 4'b1110;
    localparam logic [3:0] ALU_DIVU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } md_state_e;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_signed_md(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

    // Opcodes that must wait for the engine: anything touching hi/lo.
    function automatic logic needs_md(input logic [3:0] op);
        return is_md_op(op) || (op == ALU_MFHI) || (op == ALU_MFLO);
    endfunction

endpackage

// File: rtl/alu_md_seq.sv
// Iterative multiply/divide engine: shift-add multiply, restoring divide,
// sign fix-up and the architectural hi/lo registers.
module alu_md_seq
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             estart,
    input  logic [3:0]       ealuc,
    input  logic [WIDTH-1:0] eqa,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ebusy,
    output logic             edone
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             div_q, div_d;

    logic             start;
    logic             sign_a, sign_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod;

    assign start = estart && is_md_op(ealuc);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = is_div_op(ealuc) ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (cnt_q == CNT_LAST) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ebusy = (state_q != ST_IDLE);
        edone = (state_q == ST_FIN);
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        low_d  = low_q;
        opb_d  = opb_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        div_d  = div_q;

        sign_a    = is_signed_md(ealuc) && eqa[WIDTH-1];
        sign_b    = is_signed_md(ealuc) && b[WIDTH-1];
        mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, low_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        prod      = {acc_q, low_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    acc_d  = '0;
                    low_d  = sign_a ? -eqa : eqa;
                    opb_d  = sign_b ? -b : b;
                    // A zero divisor yields an all-ones quotient that must stay unsigned.
                    neg_d  = (sign_a ^ sign_b) && (|b);
                    rneg_d = sign_a;
                    div_d  = is_div_op(ealuc);
                end
            end
            ST_MUL: begin
                acc_d = mul_sum[WIDTH:1];
                low_d = {mul_sum[0], low_q[WIDTH-1:1]};
                cnt_d = cnt_q + SHW'(1);
            end
            ST_DIV: begin
                if (!div_diff[WIDTH]) begin
                    acc_d = div_diff[WIDTH-1:0];
                    low_d = {low_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    low_d = {low_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + SHW'(1);
            end
            ST_FIN: begin
                if (div_q) begin
                    lo_d = neg_q ? -low_q : low_q;
                    hi_d = rneg_q ? -acc_q : acc_q;
                end else begin
                    {hi_d, lo_d} = neg_q ? -prod : prod;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            low_q  <= '0;
            opb_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            low_q  <= low_d;
            opb_q  <= opb_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            div_q  <= div_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage ALU: combinational result mux plus the iterative mul/div engine.
// Define ALU_OVF_EN to build the signed ADD/SUB overflow flag on eovf.
module alu_md_unit
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] eqa,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ealuc,
    input  logic             estart,
    output logic [WIDTH-1:0] r,
    output logic             ez,
    output logic             ebusy,
    output logic             edone,
    output logic             estall,
    output logic             eovf
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] sum, diff;
    logic [SHW-1:0]   sa;

    assign sum  = eqa + b;
    assign diff = eqa - b;
    assign sa   = eqa[SHW-1:0];

    alu_md_seq #(
        .WIDTH(WIDTH)
    ) u_seq (
        .clk   (clk),
        .rst   (rst),
        .estart(estart),
        .ealuc (ealuc),
        .eqa   (eqa),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .ebusy (ebusy),
        .edone (edone)
    );

    always_comb begin
        r = '0;
        case (ealuc)
            ALU_AND:  r = eqa & b;
            ALU_OR:   r = eqa | b;
            ALU_ADD:  r = sum;
            ALU_XOR:  r = eqa ^ b;
            ALU_SUB:  r = diff;
            ALU_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(eqa) < $signed(b))};
            ALU_SLTU: r = {{(WIDTH-1){1'b0}}, (eqa < b)};
            ALU_SLL:  r = b << sa;
            ALU_SRL:  r = b >> sa;
            ALU_SRA:  r = $unsigned($signed(b) >>> sa);
            ALU_MFHI: r = hi;
            ALU_MFLO: r = lo;
            default:  r = '0;
        endcase
    end

    assign ez     = (r == '0);
    // Only hi/lo consumers wait; independent ALU ops flow past a busy engine.
    assign estall = ebusy && needs_md(ealuc);

`ifdef ALU_OVF_EN
    always_comb begin
        eovf = 1'b0;
        case (ealuc)
            ALU_ADD: eovf = (eqa[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != eqa[WIDTH-1]);
            ALU_SUB: eovf = (eqa[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != eqa[WIDTH-1]);
            default: eovf = 1'b0;
        endcase
    end
`else
    assign eovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_md_unit.sv
// Scoreboard bench for alu_md_unit: random stimulus against an arithmetic model,
// with a negedge monitor comparing every queued expectation.
module tb_alu_md_unit;
    import alu_md_pkg::*;

    localparam int W  = 32;
    localparam int NF = 5;  // ez, estall, ebusy, edone, eovf
`ifdef ALU_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         estart = 1'b0;
    logic [3:0]   ealuc = ALU_AND;
    logic [W-1:0] eqa = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] r;
    logic         ez, ebusy, edone, estall, eovf;

    always #5 clk = ~clk;

    alu_md_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .eqa   (eqa),
        .b     (b),
        .ealuc (ealuc),
        .estart(estart),
        .r     (r),
        .ez    (ez),
        .ebusy (ebusy),
        .edone (edone),
        .estall(estall),
        .eovf  (eovf)
    );

    typedef struct {
        string           name;
        logic [W+NF-1:0] exp;
        logic [W+NF-1:0] mask;
    } sb_item_t;

    sb_item_t     sb_q[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    logic [3:0] sc_ops[12] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT,
                               ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFHI, ALU_MFLO};
    logic [3:0] md_ops[4]  = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
    logic [W-1:0] edge_vals[5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, bb,
                                             input logic [W-1:0] hi, lo);
        int unsigned sh;
        sh = a % W;
        case (op)
            ALU_AND:  return a & bb;
            ALU_OR:   return a | bb;
            ALU_XOR:  return a ^ bb;
            ALU_ADD:  return a + bb;
            ALU_SUB:  return a - bb;
            ALU_SLT:  return ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < bb) ? 32'd1 : 32'd0;
            ALU_SLL:  return bb << sh;
            ALU_SRL:  return bb >> sh;
            ALU_SRA:  return (bb >> sh) | (bb[W-1] ? ~({W{1'b1}} >> sh) : '0);
            ALU_MFHI: return hi;
            ALU_MFLO: return lo;
            default:  return '0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] op, input logic [W-1:0] a, bb);
        logic [W-1:0] t;
        longint       s;
        if (!OVF_EN) return 1'b0;
        if (op == ALU_ADD) begin
            t = a + bb;
            s = longint'($signed(a)) + longint'($signed(bb));
        end else if (op == ALU_SUB) begin
            t = a - bb;
            s = longint'($signed(a)) - longint'($signed(bb));
        end else begin
            return 1'b0;
        end
        return s != longint'($signed(t));
    endfunction

    task automatic ref_md(input logic [3:0] op, input logic [W-1:0] a, bb,
                          output logic [W-1:0] nh, output logic [W-1:0] nl);
        longint      p;
        logic [63:0] pu;
        int          sa, sb;
        nh = '0;
        nl = '0;
        case (op)
            ALU_MULT: begin
                p = longint'($signed(a)) * longint'($signed(bb));
                {nh, nl} = p;
            end
            ALU_MULTU: begin
                pu = {32'b0, a} * {32'b0, bb};
                {nh, nl} = pu;
            end
            ALU_DIV: begin
                if (bb == '0) begin
                    nl = '1; nh = a;
                end else if (a == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
                    nl = a; nh = '0;
                end else begin
                    sa = a; sb = bb;
                    nl = sa / sb;
                    nh = sa % sb;
                end
            end
            default: begin
                if (bb == '0) begin
                    nl = '1; nh = a;
                end else begin
                    nl = a / bb;
                    nh = a % bb;
                end
            end
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return $urandom_range(0, 20);
            2:       return -$urandom_range(1, 20);
            default: return edge_vals[$urandom_range(0, 4)];
        endcase
    endfunction

    task automatic push(input string nm, input logic [W-1:0] er, input logic ov,
                        input logic st, input logic bz, input logic dn, input bit chk_r);
        sb_item_t it;
        it.name = nm;
        it.exp  = {er, (er == '0), st, bz, dn, ov};
        it.mask = {(chk_r ? {W{1'b1}} : {W{1'b0}}), chk_r, 1'b1, 1'b1, 1'b1, chk_r};
        sb_q.push_back(it);
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, bb, input logic st);
        ealuc  = op;
        eqa    = a;
        b      = bb;
        estart = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive an op and queue everything the model says about it.
    task automatic alu_cycle(input string nm, input logic [3:0] op, input logic [W-1:0] a, bb,
                             input logic st, input logic bz, input logic dn);
        logic stall;
        stall = bz && (op inside {ALU_MFHI, ALU_MFLO, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU});
        drive(op, a, bb, st);
        push(nm, ref_alu(op, a, bb, m_hi, m_lo), ref_ovf(op, a, bb), stall, bz, dn, 1'b1);
        step();
    endtask

    task automatic run_md(input logic [3:0] op, input logic [W-1:0] a, bb,
                          input string nm, input bit poll_lo);
        logic [W-1:0] nh, nl;
        ref_md(op, a, bb, nh, nl);
        alu_cycle({nm, " start"}, op, a, bb, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= W + 1; k++) begin
            if (poll_lo && k >= 3)
                alu_cycle({nm, " stalled mflo"}, ALU_MFLO, rand_val(), rand_val(), 1'b0, 1'b1, k == W + 1);
            else if (k == 5)
                alu_cycle({nm, " ignored start"}, md_ops[$urandom_range(0, 3)], rand_val(), rand_val(),
                          1'b1, 1'b1, 1'b0);
            else
                alu_cycle({nm, " busy alu"}, sc_ops[$urandom_range(0, 9)], rand_val(), rand_val(),
                          1'b0, 1'b1, k == W + 1);
        end
        m_hi = nh;
        m_lo = nl;
        alu_cycle({nm, " mflo"}, ALU_MFLO, rand_val(), rand_val(), 1'b0, 1'b0, 1'b0);
        alu_cycle({nm, " mfhi"}, ALU_MFHI, rand_val(), rand_val(), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_reset_mid();
        alu_cycle("rst divu start", ALU_DIVU, 32'hDEAD_BEEF, 32'd3, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 10; k++)
            alu_cycle("rst divu busy", sc_ops[$urandom_range(0, 9)], rand_val(), rand_val(), 1'b0, 1'b1, 1'b0);
        rst  = 1'b1;
        m_hi = '0;
        m_lo = '0;
        alu_cycle("rst mid-op mfhi", ALU_MFHI, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        alu_cycle("after rst mflo", ALU_MFLO, '0, '0, 1'b0, 1'b0, 1'b0);
        alu_cycle("after rst idle", ALU_ADD, rand_val(), rand_val(), 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        sb_item_t        it;
        logic [W+NF-1:0] obs;
        if (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            obs = {r, ez, estall, ebusy, edone, eovf};
            total++;
            if ((obs & it.mask) !== (it.exp & it.mask)) begin
                bad++;
                $display("FAIL %s: got r=%h ez/stall/busy/done/ovf=%b, want r=%h flags=%b",
                         it.name, r, obs[NF-1:0], it.exp[W+NF-1:NF], it.exp[NF-1:0]);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        drive(ALU_AND, '0, '0, 1'b0);
        step();
        alu_cycle("reset mfhi", ALU_MFHI, '0, '0, 1'b0, 1'b0, 1'b0);
        alu_cycle("reset mflo", ALU_MFLO, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        alu_cycle("idle after reset", ALU_AND, '0, '0, 1'b0, 1'b0, 1'b0);

        drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        push("slt -1<1", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0);
        push("sltu", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        drive(ALU_SRA, 32'd4, 32'h8000_0000, 1'b0);
        push("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        drive(ALU_SRL, 32'd4, 32'h8000_0000, 1'b0);
        push("srl", 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        push("add ovf", 32'h8000_0000, OVF_EN, 1'b0, 1'b0, 1'b0, 1'b1); step();
        drive(ALU_SUB, 32'h8000_0000, 32'd1, 1'b0);
        push("sub ovf", 32'h7FFF_FFFF, OVF_EN, 1'b0, 1'b0, 1'b0, 1'b1); step();

        for (int i = 0; i < 40; i++)
            alu_cycle("rand alu", sc_ops[$urandom_range(0, 11)], rand_val(), rand_val(), 1'b0, 1'b0, 1'b0);

        run_md(ALU_MULT, 32'hFFFF_FFFD, 32'd7, "mult -3*7", 1'b1);
        run_reset_mid();
        run_md(ALU_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2", 1'b0);
        run_md(ALU_DIVU, 32'd5, 32'd0, "divu 5/0", 1'b0);
        run_md(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1", 1'b0);
        run_md(ALU_DIV, 32'hFFFF_FFF8, 32'd0, "div -8/0", 1'b0);
        run_md(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", 1'b1);

        for (int i = 0; i < 16; i++)
            run_md(md_ops[$urandom_range(0, 3)], rand_val(), rand_val(), "rand md", bit'($urandom_range(0, 1)));

        drive(ALU_AND, '0, '0, 1'b0);
        step();
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
